ring_phase_monitor: RTL and testbench

//  Downstream checker for the one-hot ring counter. Samples the ring's phase

---
 rtl/ring_phase_monitor_if.sv | 29 ++
 rtl/ring_phase_monitor.sv | 150 +++++++++++++++
 tb/tb_ring_phase_monitor.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ring_phase_monitor_if.sv
// Phase-monitor bundle: ring phase/control in, lock/revolution/error status out.
// The master side drives the ring samples; the monitor is the slave.
interface ring_phase_monitor_if #(
   parameter int WIDTH = 4,
   parameter int REV_W = 8,
   parameter int ERR_W = 4
);
   logic             sync;
   logic             en;
   logic [WIDTH-1:0] phase;
   logic             locked;
   logic             rev_pulse;
   logic [REV_W-1:0] rev_count;
   logic             err;
   logic [ERR_W-1:0] err_count;
   logic             err_sticky;

   modport master (
      output sync, en, phase,
      input  locked, rev_pulse, rev_count,
      input  err, err_count, err_sticky
   );

   modport slave (
      input  sync, en, phase,
      output locked, rev_pulse, rev_count,
      output err, err_count, err_sticky
   );
endinterface

// File: rtl/ring_phase_monitor.sv
// Checks a one-hot ring counter for legal left rotation, tracks lock,
// counts revolutions and counts/flags sequence errors.
module ring_phase_monitor #(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 2,
   parameter int REV_W    = 8,
   parameter int ERR_W    = 4
) (
   input logic                 clk,
   input logic                 rst,
   ring_phase_monitor_if.slave mon
);

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_CNT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACQUIRE,
      LOCKED
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic [GW-1:0]    good_q, good_d;
   logic             locked_q, locked_d;
   logic             rev_q, rev_d;
   logic             err_q, err_d;
   logic             sticky_q, sticky_d;
   logic [REV_W-1:0] revc_q, revc_d;
   logic [ERR_W-1:0] errc_q, errc_d;

   logic             legal;
   logic             hit;
   logic             fault;

   function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] p);
      return {p[WIDTH-2:0], p[WIDTH-1]};
   endfunction

   assign legal = $onehot(mon.phase);
   assign hit   = (mon.phase == exp_q);
   // With the ring stalled, any movement at all is a fault.
   assign fault = mon.en ? !hit : (mon.phase != last_q);

   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      last_d   = mon.phase;
      good_d   = good_q;
      locked_d = locked_q;
      rev_d    = 1'b0;
      err_d    = 1'b0;
      sticky_d = sticky_q;
      revc_d   = revc_q;
      errc_d   = errc_q;

      if (mon.sync) begin
         state_d  = IDLE;
         good_d   = '0;
         locked_d = 1'b0;
         sticky_d = 1'b0;
         revc_d   = '0;
         errc_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (legal) begin
                  state_d = ACQUIRE;
                  exp_d   = rot(mon.phase);
                  good_d  = '0;
               end
            end
            ACQUIRE: begin
               if (mon.en) begin
                  if (!legal) begin
                     state_d = IDLE;
                  end else if (hit) begin
                     exp_d  = rot(exp_q);
                     good_d = good_q + 1'b1;
                     if (good_q == LOCK_LAST) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                     end
                  end else begin
                     exp_d  = rot(mon.phase);
                     good_d = '0;
                  end
               end
            end
            LOCKED: begin
               if (fault) begin
                  state_d  = IDLE;
                  locked_d = 1'b0;
                  err_d    = 1'b1;
                  sticky_d = 1'b1;
                  if (!(&errc_q)) begin
                     errc_d = errc_q + 1'b1;
                  end
               end else if (mon.en) begin
                  exp_d = rot(exp_q);
                  if (mon.phase[0]) begin
                     rev_d  = 1'b1;
                     revc_d = revc_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d  = IDLE;
               locked_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         exp_q    <= '0;
         last_q   <= '0;
         good_q   <= '0;
         locked_q <= 1'b0;
         rev_q    <= 1'b0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
         revc_q   <= '0;
         errc_q   <= '0;
      end else begin
         state_q  <= state_d;
         exp_q    <= exp_d;
         last_q   <= last_d;
         good_q   <= good_d;
         locked_q <= locked_d;
         rev_q    <= rev_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
         revc_q   <= revc_d;
         errc_q   <= errc_d;
      end
   end

   assign mon.locked     = locked_q;
   assign mon.rev_pulse  = rev_q;
   assign mon.rev_count  = revc_q;
   assign mon.err        = err_q;
   assign mon.err_count  = errc_q;
   assign mon.err_sticky = sticky_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Bench for ring_phase_monitor: directed scenarios plus random ring traffic,
// all outputs compared every cycle against an index-based behavioural model.
module tb_ring_phase_monitor;

   localparam int W    = 4;
   localparam int LOCK = 2;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   bit   cmp_on;

   ring_phase_monitor_if #(.WIDTH(W), .REV_W(8), .ERR_W(4)) mon ();

   ring_phase_monitor #(
      .WIDTH(W), .LOCK_CNT(LOCK), .REV_W(8), .ERR_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mon(mon)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Behavioural model: the expected phase is held as a bit position.
   int       m_mode;
   int       m_pos;
   int       m_good;
   logic [W-1:0] m_prev;
   int       m_locked, m_rev, m_err, m_sticky, m_errc;
   logic [7:0] m_revc;

   function automatic int pos_of(input logic [W-1:0] p);
      for (int i = 0; i < W; i++) if (p[i]) return i;
      return -1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_mode = 0; m_pos = 0; m_good = 0; m_prev = '0;
         m_locked = 0; m_rev = 0; m_err = 0; m_sticky = 0;
         m_errc = 0; m_revc = '0;
      end else begin
         int  ones;
         int  p;
         bit  bad;
         ones  = $countones(mon.phase);
         p     = pos_of(mon.phase);
         m_rev = 0;
         m_err = 0;
         if (mon.sync) begin
            m_mode = 0; m_good = 0; m_locked = 0;
            m_sticky = 0; m_errc = 0; m_revc = '0;
         end else if (m_mode == 0) begin
            if (ones == 1) begin
               m_mode = 1; m_pos = (p + 1) % W; m_good = 0;
            end
         end else if (m_mode == 1) begin
            if (mon.en) begin
               if (ones != 1) m_mode = 0;
               else if (p == m_pos) begin
                  m_pos = (m_pos + 1) % W;
                  m_good++;
                  if (m_good == LOCK) begin
                     m_mode = 2; m_locked = 1;
                  end
               end else begin
                  m_pos = (p + 1) % W; m_good = 0;
               end
            end
         end else begin
            if (mon.en) bad = (ones != 1) || (p != m_pos);
            else        bad = (mon.phase != m_prev);
            if (bad) begin
               m_err = 1; m_sticky = 1; m_locked = 0; m_mode = 0;
               if (m_errc < 15) m_errc++;
            end else if (mon.en) begin
               if (p == 0) begin
                  m_rev = 1; m_revc = m_revc + 8'd1;
               end
               m_pos = (m_pos + 1) % W;
            end
         end
         m_prev = mon.phase;
      end
   end

   always @(negedge clk) begin
      if (cmp_on && rst === 1'b1) begin
         chk("m_locked", int'(mon.locked), m_locked);
         chk("m_rev_pulse", int'(mon.rev_pulse), m_rev);
         chk("m_rev_count", int'(mon.rev_count), int'(m_revc));
         chk("m_err", int'(mon.err), m_err);
         chk("m_err_count", int'(mon.err_count), m_errc);
         chk("m_err_sticky", int'(mon.err_sticky), m_sticky);
      end
   end

   task automatic drive(input logic [W-1:0] p, input logic e, input logic s);
      @(negedge clk);
      mon.phase = p;
      mon.en    = e;
      mon.sync  = s;
      @(posedge clk);
      #1;
   endtask

   task automatic all_zero(input string tag);
      chk({tag, "_locked"}, int'(mon.locked), 0);
      chk({tag, "_rev_pulse"}, int'(mon.rev_pulse), 0);
      chk({tag, "_rev_count"}, int'(mon.rev_count), 0);
      chk({tag, "_err"}, int'(mon.err), 0);
      chk({tag, "_err_count"}, int'(mon.err_count), 0);
      chk({tag, "_err_sticky"}, int'(mon.err_sticky), 0);
   endtask

   function automatic logic [W-1:0] rot(input logic [W-1:0] p);
      return {p[W-2:0], p[W-1]};
   endfunction

   logic [W-1:0] ring;
   logic [W-1:0] rp;
   int           r;
   logic         e;

   initial begin
      checks = 0;
      errors = 0;
      cmp_on = 1'b0;
      rst = 1'b1;
      mon.phase = 4'b0001;
      mon.en    = 1'b1;
      mon.sync  = 1'b0;
      #1 rst = 1'b0;
      #2 all_zero("reset");
      #7 rst = 1'b1;
      cmp_on = 1'b1;

      // Free-running ring from 0001.
      ring = 4'b0001;
      for (int i = 1; i <= 10; i++) begin
         drive(ring, 1'b1, 1'b0);
         ring = rot(ring);
         if (i == 2) chk("t1_unlocked", int'(mon.locked), 0);
         if (i == 3) chk("t1_locked", int'(mon.locked), 1);
         if (i == 5) begin
            chk("t1_rev_pulse", int'(mon.rev_pulse), 1);
            chk("t1_rev_count", int'(mon.rev_count), 1);
         end
      end
      chk("t1_err_count", int'(mon.err_count), 0);
      chk("t1_rev_count2", int'(mon.rev_count), 2);

      // Illegal sample while locked, then relock.
      drive(4'b0110, 1'b1, 1'b0);
      chk("t2_err", int'(mon.err), 1);
      chk("t2_err_count", int'(mon.err_count), 1);
      chk("t2_sticky", int'(mon.err_sticky), 1);
      chk("t2_locked", int'(mon.locked), 0);
      drive(4'b1000, 1'b1, 1'b0);
      drive(4'b0001, 1'b1, 1'b0);
      chk("t2_not_yet", int'(mon.locked), 0);
      drive(4'b0010, 1'b1, 1'b0);
      chk("t2_relock", int'(mon.locked), 1);
      chk("t2_sticky_hold", int'(mon.err_sticky), 1);
      chk("t2_rev_hold", int'(mon.rev_count), 2);

      // Stalled ring: held phase is fine, a moved phase is an error.
      repeat (3) begin
         drive(4'b0010, 1'b0, 1'b0);
         chk("t3_hold_locked", int'(mon.locked), 1);
         chk("t3_hold_err", int'(mon.err), 0);
      end
      drive(4'b0100, 1'b0, 1'b0);
      chk("t3_err", int'(mon.err), 1);
      chk("t3_err_count", int'(mon.err_count), 2);

      // Skipped position.
      drive(4'b0100, 1'b1, 1'b0);
      drive(4'b1000, 1'b1, 1'b0);
      drive(4'b0001, 1'b1, 1'b0);
      chk("t4_locked", int'(mon.locked), 1);
      drive(4'b0100, 1'b1, 1'b0);
      chk("t4_skip_err", int'(mon.err), 1);
      chk("t4_err_count", int'(mon.err_count), 3);

      // Drive the error counter into saturation.
      for (int k = 1; k <= 15; k++) begin
         drive(4'b0001, 1'b1, 1'b0);
         drive(4'b0010, 1'b1, 1'b0);
         drive(4'b0100, 1'b1, 1'b0);
         drive(4'b1001, 1'b1, 1'b0);
         chk("t4_sat_err", int'(mon.err), 1);
         chk("t4_sat_count", int'(mon.err_count), (3 + k > 15) ? 15 : 3 + k);
      end

      // Sync together with an injected error.
      drive(4'b0001, 1'b1, 1'b0);
      drive(4'b0010, 1'b1, 1'b0);
      drive(4'b0100, 1'b1, 1'b0);
      chk("t5_locked", int'(mon.locked), 1);
      drive(4'b0110, 1'b1, 1'b1);
      all_zero("t5_sync");

      // Revolution counter wrap.
      drive(4'b0001, 1'b1, 1'b0);
      drive(4'b0010, 1'b1, 1'b0);
      drive(4'b0100, 1'b1, 1'b0);
      drive(4'b1000, 1'b1, 1'b0);
      ring = 4'b0001;
      repeat (255 * 4) begin
         drive(ring, 1'b1, 1'b0);
         ring = rot(ring);
      end
      chk("t4_rev_255", int'(mon.rev_count), 255);
      drive(4'b0001, 1'b1, 1'b0);
      chk("t4_wrap_pulse", int'(mon.rev_pulse), 1);
      chk("t4_wrap_count", int'(mon.rev_count), 0);

      // Asynchronous reset between edges.
      drive(4'b0010, 1'b1, 1'b0);
      #2 rst = 1'b0;
      #1 all_zero("t6_async");
      #1 rst = 1'b1;
      drive(4'b0001, 1'b1, 1'b0);
      drive(4'b0010, 1'b1, 1'b0);
      chk("t6_unlocked", int'(mon.locked), 0);
      drive(4'b0100, 1'b1, 1'b0);
      chk("t6_locked", int'(mon.locked), 1);

      // Random ring traffic with stalls, glitches and syncs.
      ring = 4'b1000;
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 99));
         e = ($urandom_range(0, 3) != 0);
         rp = 4'($urandom);
         if (r < 3)       drive(ring, e, 1'b1);
         else if (r < 8)  drive(rp, e, 1'b0);
         else             drive(ring, e, 1'b0);
         if (e) ring = rot(ring);
      end

      @(negedge clk);
      cmp_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
